adau_cmd_arbiter: RTL and testbench
===================================

Name: adau_cmd_arbiter

Overview:
- Shares the single ADAU SPI control-port master between two command sources:
  - the boot-time ADAU init command list;
  - a CPU-driven command queue written through the Wishbone register block.
- Buffers CPU commands in a small FIFO and blocks CPU traffic until codec init completes.
- Arbitrates round-robin after init.
- Enforces a minimum idle gap between SPI frames.
- Sits between the command list, the bus logic and the SPI master in the top level, all in the SoC clock domain.

Parameters:
- FIFO_DEPTH, 4, CPU command FIFO entries; power of 2, at least 2.
- GAP_CYCLES, 16, idle clk cycles enforced after each SPI handshake; at least 2.
- CMD_W, 32, command word width: {chip addr, reg addr, r/w, data}, passed through opaque.

Ports:
- clk  in  1  SoC clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- init_cmd  in  CMD_W  command from init sequencer.
- init_valid  in  1  init command pending.
- init_ready  out  1  init command accepted this cycle.
- init_done  in  1  init sequence finished; level signal.
- cpu_cmd  in  CMD_W  command word from bus register write.
- cpu_push  in  1  single-cycle write strobe.
- cpu_full  out  1  FIFO full.
- cpu_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- cpu_overflow  out  1  sticky: a push was dropped.
- cpu_overflow_clr  in  1  clears cpu_overflow.
- spi_cmd  out  CMD_W  command to SPI master.
- spi_valid  out  1  command offered to SPI master.
- spi_ready  in  1  SPI master idle/accepting.
- busy  out  1  state != IDLE, or FIFO non-empty.
- owner  out  1  0 = init, 1 = CPU; the grant currently held or last held.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, FIFO empty, cpu_overflow=0, owner=0, gap counter=0;
  - spi_valid=0, init_ready=0, spi_cmd=0.
  - Effect on outputs is immediate, including mid-transfer. The SPI master is reset by the same reset.
- FSM states: IDLE, ISSUE, GAP, DRAIN.
- IDLE, source selection:
  - Candidates are init (init_valid) and CPU (FIFO non-empty AND init_done=1).
  - Only one candidate: grant it.
  - Both candidates: grant the source other than owner (round-robin).
- IDLE, on grant:
  - Init grant: init_ready=1 combinationally in the same cycle.
  - CPU grant: FIFO pop in the same cycle.
  - Command latched into spi_cmd; owner updated; next state ISSUE.
  - Latency: accept at cycle N, spi_valid=1 at N+1.
- ISSUE:
  - spi_valid=1; spi_cmd held stable.
  - On spi_valid & spi_ready: load counter with GAP_CYCLES-1, go to GAP. spi_valid=0 from the next cycle.
- GAP: decrement the counter; at 0 go to DRAIN. The counter masks the master's ready deassert latency.
- DRAIN: wait for spi_ready=1, then IDLE. The next grant is possible in the cycle IDLE is entered.
- Throughput: at most one command per (GAP_CYCLES + 2 + SPI frame time).
- FIFO:
  - Push is accepted when not full.
  - Push while full with a simultaneous pop is accepted; level unchanged.
  - Push while full without a pop is dropped and sets cpu_overflow.
  - cpu_overflow_clr in the same cycle as a dropping push: set wins.
  - Pointers wrap modulo FIFO_DEPTH. Level is exact from 0 to FIFO_DEPTH.
- init_done deasserting (re-init) blocks further CPU grants. An in-flight CPU command completes normally.
- init_valid is not required to be held. If it drops before grant, nothing is issued.
- init_ready is never asserted outside IDLE.

Decomposition:
- Shared package adau_ctrl_pkg holds:
  - state encoding (IDLE/ISSUE/GAP/DRAIN);
  - OWNER_INIT and OWNER_CPU constants;
  - GAP_MIN=2, used in a parameter assertion;
  - CMD_W default.
- One sub-module: adau_cmd_fifo, a synchronous FIFO with push/pop, full/empty, level and async active-low reset.

Test Plan:
- Reset, then init_valid=1, init_cmd=32'h0040_0001, init_done=0, spi_ready=1 → init_ready pulse at cycle 0; spi_valid=1 and spi_cmd=32'h0040_0001 at cycle 1; one handshake; no further spi_valid until at least GAP_CYCLES+1 cycles later.
- init_done=0, CPU pushes 3 commands → cpu_level=3, spi_valid never asserts. Raise init_done → the 3 commands are issued in push order, cpu_level reaching 0.
- init_done=1, init_valid held high, FIFO holding A and B → issue order alternates init, A, init, B; owner toggles on each grant.
- FIFO_DEPTH=4: 5 pushes with spi_ready=0 → cpu_full=1, cpu_level=4, cpu_overflow=1. Issuing cpu_overflow_clr afterwards → cpu_overflow=0.
- Push on the exact cycle of an IDLE pop with the FIFO full → cpu_level stays 4, no overflow.
- rstn=0 during ISSUE with spi_ready=0 → spi_valid=0 immediately. After release: IDLE, empty FIFO, owner=0, busy=0.

Source files
------------

// File: rtl/adau_ctrl_pkg.sv
// Shared definitions for the ADAU control-port command path.
package adau_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam logic OWNER_INIT = 1'b0;
  localparam logic OWNER_CPU  = 1'b1;

  localparam int GAP_MIN   = 2;
  localparam int CMD_W_DEF = 32;

endpackage

// File: rtl/adau_cmd_fifo.sv
// Small synchronous FIFO for CPU-issued codec commands; reports pushes
// dropped because the FIFO was full with no simultaneous pop.
module adau_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_push, do_pop;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == LW'(DEPTH));
  assign level_o = lvl_q;
  assign dout_o  = mem_q[rd_q];

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;

  always_comb begin
    lvl_d = lvl_q;
    case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/adau_cmd_arbiter.sv
// Shares the ADAU SPI control-port master between the boot init list and a
// CPU command FIFO, round-robin after init, with a fixed idle gap per frame.
module adau_cmd_arbiter
  import adau_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16,
  parameter int CMD_W      = CMD_W_DEF
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [CMD_W-1:0]                init_cmd,
  input  logic                            init_valid,
  output logic                            init_ready,
  input  logic                            init_done,
  input  logic [CMD_W-1:0]                cpu_cmd,
  input  logic                            cpu_push,
  output logic                            cpu_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] cpu_level,
  output logic                            cpu_overflow,
  input  logic                            cpu_overflow_clr,
  output logic [CMD_W-1:0]                spi_cmd,
  output logic                            spi_valid,
  input  logic                            spi_ready,
  output logic                            busy,
  output logic                            owner
);

  localparam int GW = $clog2(GAP_CYCLES);

  if (GAP_CYCLES < GAP_MIN) begin : g_bad_gap
    $error("adau_cmd_arbiter: GAP_CYCLES below minimum");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_depth
    $error("adau_cmd_arbiter: FIFO_DEPTH must be a power of 2 >= 2");
  end

  arb_state_e       state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             owner_q, owner_d;
  logic             ovf_q;
  logic             fifo_empty, fifo_drop, fifo_pop;
  logic [CMD_W-1:0] fifo_dout;
  logic             cand_init, cand_cpu, pick_cpu;

  adau_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (cpu_push),
    .din_i   (cpu_cmd),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (cpu_full),
    .empty_o (fifo_empty),
    .level_o (cpu_level),
    .drop_o  (fifo_drop)
  );

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    cmd_d      = cmd_q;
    owner_d    = owner_q;
    fifo_pop   = 1'b0;
    init_ready = 1'b0;
    cand_init  = init_valid;
    cand_cpu   = ~fifo_empty & init_done;
    // On contention the source that did not hold the last grant wins.
    pick_cpu   = cand_cpu & (~cand_init | (owner_q == OWNER_INIT));
    case (state_q)
      ST_IDLE: begin
        // rstn gating keeps init_ready low while reset is asserted.
        if (rstn && (cand_init || cand_cpu)) begin
          state_d    = ST_ISSUE;
          owner_d    = pick_cpu ? OWNER_CPU : OWNER_INIT;
          cmd_d      = pick_cpu ? fifo_dout : init_cmd;
          fifo_pop   = pick_cpu;
          init_ready = ~pick_cpu;
        end
      end
      ST_ISSUE: begin
        if (spi_ready) begin
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_DRAIN;
        else             gap_d   = gap_q - GW'(1);
      end
      ST_DRAIN: begin
        if (spi_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      cmd_q   <= '0;
      owner_q <= OWNER_INIT;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
      if (fifo_drop)             ovf_q <= 1'b1;
      else if (cpu_overflow_clr) ovf_q <= 1'b0;
    end
  end

  assign spi_valid    = (state_q == ST_ISSUE);
  assign spi_cmd      = cmd_q;
  assign owner        = owner_q;
  assign cpu_overflow = ovf_q;
  assign busy         = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_adau_cmd_arbiter.sv
// Bench for adau_cmd_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a timing/queue model of the arbiter.
module tb_adau_cmd_arbiter;

  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] init_cmd = '0, cpu_cmd = '0;
  logic         init_valid = 0, init_done = 0, cpu_push = 0;
  logic         cpu_overflow_clr = 0, spi_ready = 0;
  logic         init_ready, cpu_full, cpu_overflow, spi_valid, busy, owner;
  logic [2:0]   cpu_level;
  logic [W-1:0] spi_cmd;

  adau_cmd_arbiter #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .CMD_W(W)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .init_cmd         (init_cmd),
    .init_valid       (init_valid),
    .init_ready       (init_ready),
    .init_done        (init_done),
    .cpu_cmd          (cpu_cmd),
    .cpu_push         (cpu_push),
    .cpu_full         (cpu_full),
    .cpu_level        (cpu_level),
    .cpu_overflow     (cpu_overflow),
    .cpu_overflow_clr (cpu_overflow_clr),
    .spi_cmd          (spi_cmd),
    .spi_valid        (spi_valid),
    .spi_ready        (spi_ready),
    .busy             (busy),
    .owner            (owner)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: arbiter is either free to grant, holding an offered command, or
  // blocked until a time derived from the last handshake cycle.
  logic [W-1:0] mq[$];
  bit           m_idle, m_pend, m_owner, m_ovf;
  logic [W-1:0] m_cmd;
  int           cyc, m_hs;
  int           n_grant_init, n_grant_cpu;

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit cpu_cand();
    return (mq.size() != 0) && init_done;
  endfunction

  function automatic bit g_cpu();
    return m_idle && cpu_cand() && (!init_valid || !m_owner);
  endfunction

  function automatic bit g_init();
    return m_idle && init_valid && !g_cpu();
  endfunction

  task automatic model_reset();
    mq.delete();
    m_idle = 1; m_pend = 0; m_owner = 0; m_ovf = 0; m_cmd = '0;
    m_hs = -1000;
  endtask

  task automatic model_clk();
    bit gi, gc, drop;
    gi = g_init();
    gc = g_cpu();
    if (gi || gc) begin
      m_idle = 0; m_pend = 1; m_owner = gc;
      m_cmd  = gc ? mq[0] : init_cmd;
      if (gc) begin void'(mq.pop_front()); n_grant_cpu++; end
      else n_grant_init++;
    end else if (m_pend && spi_ready) begin
      m_pend = 0; m_hs = cyc;
    end else if (!m_idle && !m_pend && cyc >= m_hs + GAP + 1 && spi_ready) begin
      m_idle = 1;
    end
    drop = 0;
    if (cpu_push) begin
      if (mq.size() < DEPTH) mq.push_back(cpu_cmd);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (cpu_overflow_clr) m_ovf = 0;
    cyc++;
  endtask

  task automatic check_outs();
    chk("init_ready", init_ready, g_init());
    chk("spi_valid", spi_valid, m_pend);
    chk("spi_cmd", spi_cmd, m_cmd);
    chk("cpu_level", cpu_level, mq.size());
    chk("cpu_full", cpu_full, mq.size() == DEPTH);
    chk("cpu_overflow", cpu_overflow, m_ovf);
    chk("owner", owner, m_owner);
    chk("busy", busy, !m_idle || mq.size() != 0);
  endtask

  task automatic step();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_cmd(logic [W-1:0] v);
    cpu_cmd = v; cpu_push = 1;
    step();
    cpu_push = 0;
  endtask

  // Asserted mid-cycle: outputs must drop without waiting for a clock edge.
  task automatic apply_reset();
    #2;
    rstn = 0;
    #1;
    chk("rst_spi_valid", spi_valid, 0);
    chk("rst_init_ready", init_ready, 0);
    chk("rst_spi_cmd", spi_cmd, 0);
    init_valid = 0; cpu_push = 0; cpu_overflow_clr = 0; init_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_grant_init = 0; n_grant_cpu = 0;
    model_reset();
    apply_reset();
    run(3);

    // Single init command before init_done, then the mandatory gap.
    init_valid = 1; init_cmd = 32'h0040_0001; spi_ready = 1;
    step();
    init_valid = 0;
    run(GAP + 8);

    // CPU commands blocked until init_done, then issued in order.
    push_cmd(32'hC000_0001);
    push_cmd(32'hC000_0002);
    push_cmd(32'hC000_0003);
    run(10);
    chk("blocked_level", cpu_level, 3);
    init_done = 1;
    run(3 * (GAP + 3) + 10);
    chk("drained_level", cpu_level, 0);

    // Round-robin: init held high against FIFO entries A and B.
    init_done = 0;
    push_cmd(32'hAAAA_0001);
    push_cmd(32'hBBBB_0002);
    init_done = 1; init_valid = 1; init_cmd = 32'h0011_2233;
    run(4 * (GAP + 3) + 5);
    init_valid = 0;
    run(GAP + 5);

    // Overflow: five pushes into a depth-4 FIFO with CPU grants blocked.
    init_done = 0; spi_ready = 0;
    for (int i = 0; i < 5; i++) push_cmd(32'hD000_0000 + i);
    chk("ovf_level", cpu_level, 4);
    chk("ovf_flag", cpu_overflow, 1);
    cpu_overflow_clr = 1;
    step();
    cpu_overflow_clr = 0;
    step();

    // Push while full on the exact cycle of an IDLE pop.
    spi_ready = 1; init_done = 1;
    push_cmd(32'hE000_0005);
    run(5 * (GAP + 3) + 10);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      init_valid       = ($urandom_range(0, 99) < 30);
      init_cmd         = $urandom;
      cpu_push         = ($urandom_range(0, 99) < 15);
      cpu_cmd          = $urandom;
      spi_ready        = ($urandom_range(0, 99) < 70);
      cpu_overflow_clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 3) init_done = ~init_done;
      step();
    end
    cpu_push = 0; cpu_overflow_clr = 0; init_valid = 0;
    chk("rand_grants_seen", (n_grant_init > 10) && (n_grant_cpu > 10), 1);

    // Reset while a command is offered and the master is not ready.
    init_done = 1; spi_ready = 1; init_valid = 1; init_cmd = 32'h0099_0077;
    for (int i = 0; i < 200 && !m_pend; i++) step();
    spi_ready = 0;
    if (!m_pend) chk("issue_timeout", spi_valid, 1);
    run(2);
    chk("pre_rst_valid", spi_valid, 1);
    push_cmd(32'hF000_0001);
    apply_reset();
    run(4);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_owner", owner, 0);
    chk("post_rst_level", cpu_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
